// File: rtl/health_bar_trail.sv
// health_bar_trail: per-slot enemy health bar with a delayed damage trail and
// a blinking hit flash, rendered as a 4-bit palette index one cycle after the
// pixel coordinate arrives.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   frame_tick          one-cycle per-frame pulse; advances trail and flash
//   x, y                enemy-local pixel coordinate
//   is_enemy_in_pixel   an enemy covers the current pixel
//   slot_sel            slot of the enemy covering the pixel
//   enemy_type          type of the selected slot, selects the bar scale
//   health              flat per-slot health, slot k at [k*HEALTH_W +: HEALTH_W]
//   enemy_active        per-slot active flag
//   spawn               per-slot (re)spawn pulse
//   pixel               registered palette index, 0 = transparent
module health_bar_trail #(
    parameter int unsigned N_SLOTS      = 4,
    parameter int unsigned HEALTH_W     = 8,
    parameter int unsigned BAR_WIDTH    = 32,
    parameter int unsigned BAR_HEIGHT   = 3,
    parameter int unsigned X_OFFSET     = 2,
    parameter int unsigned TRAIL_STEP   = 1,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned COL_FILL     = 6,
    parameter int unsigned COL_EMPTY    = 2,
    parameter int unsigned COL_TRAIL    = 4,
    parameter int unsigned COL_FLASH    = 15,
    localparam int unsigned SEL_W       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         frame_tick,
    input  logic [9:0]                   x,
    input  logic [9:0]                   y,
    input  logic                         is_enemy_in_pixel,
    input  logic [SEL_W-1:0]             slot_sel,
    input  logic [3:0]                   enemy_type,
    input  logic [N_SLOTS*HEALTH_W-1:0]  health,
    input  logic [N_SLOTS-1:0]           enemy_active,
    input  logic [N_SLOTS-1:0]           spawn,
    output logic [3:0]                   pixel
);

    localparam int unsigned FL_W  = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned SW    = HEALTH_W + 3;
    localparam int unsigned CW    = (SW > 10) ? SW : 10;
    localparam int unsigned SEL_N = 1 << SEL_W;

    logic [HEALTH_W-1:0] health_s [N_SLOTS];
    logic [HEALTH_W-1:0] trail_q  [N_SLOTS];
    logic [HEALTH_W-1:0] trail_d  [N_SLOTS];
    logic [HEALTH_W-1:0] prev_q   [N_SLOTS];
    logic [HEALTH_W-1:0] prev_d   [N_SLOTS];
    logic [FL_W-1:0]     flash_q  [N_SLOTS];
    logic [FL_W-1:0]     flash_d  [N_SLOTS];

    // Selector views padded to the full slot_sel range; unused codes read as inactive.
    logic [HEALTH_W-1:0] h_ext [SEL_N];
    logic [HEALTH_W-1:0] t_ext [SEL_N];
    logic                f_ext [SEL_N];
    logic                a_ext [SEL_N];

    logic [3:0]          pixel_q;
    logic [3:0]          pixel_d;

    logic [HEALTH_W-1:0] h_sel;
    logic [HEALTH_W-1:0] t_sel;
    logic [SW-1:0]       fill_w;
    logic [SW-1:0]       trail_w;
    logic [9:0]          col;
    logic                bar_hit;

    for (genvar k = 0; k < SEL_N; k++) begin : g_slot
        if (k < N_SLOTS) begin : g_real
            assign health_s[k] = health[k*HEALTH_W +: HEALTH_W];
            assign h_ext[k]    = health_s[k];
            assign t_ext[k]    = trail_q[k];
            assign f_ext[k]    = flash_q[k][0];
            assign a_ext[k]    = enemy_active[k];
        end else begin : g_pad
            assign h_ext[k]    = '0;
            assign t_ext[k]    = '0;
            assign f_ext[k]    = 1'b0;
            assign a_ext[k]    = 1'b0;
        end
    end

    // Per-slot trail / flash / previous-health update.
    always_comb begin
        for (int k = 0; k < N_SLOTS; k++) begin
            trail_d[k] = trail_q[k];
            prev_d[k]  = prev_q[k];
            flash_d[k] = flash_q[k];
        end
        for (int k = 0; k < N_SLOTS; k++) begin
            if (!enemy_active[k]) begin
                trail_d[k] = '0;
                prev_d[k]  = '0;
                flash_d[k] = '0;
            end else if (spawn[k]) begin
                trail_d[k] = health_s[k];
                prev_d[k]  = health_s[k];
                flash_d[k] = '0;
            end else begin
                prev_d[k] = health_s[k];
                if (frame_tick) begin
                    // Heals snap the trail up; damage drains it, never below health.
                    if (health_s[k] >= trail_q[k]) begin
                        trail_d[k] = health_s[k];
                    end else if ((trail_q[k] - health_s[k]) > HEALTH_W'(TRAIL_STEP)) begin
                        trail_d[k] = trail_q[k] - HEALTH_W'(TRAIL_STEP);
                    end else begin
                        trail_d[k] = health_s[k];
                    end
                end
                // A fresh hit reloads the flash even on a frame tick.
                if (health_s[k] < prev_q[k]) begin
                    flash_d[k] = FL_W'(FLASH_FRAMES);
                end else if (frame_tick && (flash_q[k] != '0)) begin
                    flash_d[k] = flash_q[k] - FL_W'(1);
                end
            end
        end
    end

    // Pixel colour from pre-update state.
    always_comb begin
        pixel_d = 4'd0;
        h_sel   = h_ext[slot_sel];
        t_sel   = t_ext[slot_sel];
        col     = x - 10'(X_OFFSET);
        bar_hit = is_enemy_in_pixel && a_ext[slot_sel] &&
                  (x >= 10'(X_OFFSET)) && (x < 10'(BAR_WIDTH)) &&
                  (y < 10'(BAR_HEIGHT));
        case (enemy_type)
            4'd0: begin
                fill_w  = SW'(h_sel) << 2;
                trail_w = SW'(t_sel) << 2;
            end
            4'd1: begin
                fill_w  = SW'(h_sel) << 3;
                trail_w = SW'(t_sel) << 3;
            end
            4'd3: begin
                fill_w  = SW'(h_sel >> 2);
                trail_w = SW'(t_sel >> 2);
            end
            default: begin
                fill_w  = SW'(h_sel);
                trail_w = SW'(t_sel);
            end
        endcase
        if (bar_hit) begin
            if (CW'(col) < CW'(fill_w)) begin
                pixel_d = f_ext[slot_sel] ? 4'(COL_FLASH) : 4'(COL_FILL);
            end else if (CW'(col) < CW'(trail_w)) begin
                pixel_d = 4'(COL_TRAIL);
            end else begin
                pixel_d = 4'(COL_EMPTY);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pixel_q <= 4'd0;
            for (int k = 0; k < N_SLOTS; k++) begin
                trail_q[k] <= '0;
                prev_q[k]  <= '0;
                flash_q[k] <= '0;
            end
        end else begin
            pixel_q <= pixel_d;
            for (int k = 0; k < N_SLOTS; k++) begin
                trail_q[k] <= trail_d[k];
                prev_q[k]  <= prev_d[k];
                flash_q[k] <= flash_d[k];
            end
        end
    end

    assign pixel = pixel_q;

endmodule

// File: doc/health_bar_trail.md
# health_bar_trail

Multi-slot enemy health-bar renderer with a delayed "damage trail" and a blinking hit flash. It sits in the sprite pixel pipeline beside the enemy renderer and takes the enemy-local pixel coordinate, the enemy slot occupying that pixel, and per-slot health. It emits a 4-bit palette index each cycle, which the compositor overlays on the enemy sprite. Per-slot trail and flash state advance once per frame on `frame_tick`.

## Interface
- `N_SLOTS`, 4: number of enemy slots tracked.
- `HEALTH_W`, 8: health width per slot.
- `BAR_WIDTH`, 32: x bound, exclusive, of the bar region in enemy-local coordinates.
- `BAR_HEIGHT`, 3: y bound, exclusive, of the bar region.
- `X_OFFSET`, 2: first bar column in enemy-local x.
- `TRAIL_STEP`, 1: health units the trail drains per frame.
- `FLASH_FRAMES`, 8: flash duration in frames; the counter is `$clog2(FLASH_FRAMES+1)` bits wide.
- `COL_FILL`, 6; `COL_EMPTY`, 2; `COL_TRAIL`, 4; `COL_FLASH`, 15: palette indices.

Ports:
- `CLK`  in  1  system clock; everything is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per frame, issued in vblank.
- `x`, `y`  in  10 each  enemy-local pixel coordinate.
- `is_enemy_in_pixel`  in  1  an enemy covers the current pixel.
- `slot_sel`  in  `$clog2(N_SLOTS)`  slot of the enemy covering the pixel.
- `enemy_type`  in  4  type of the selected slot.
- `health`  in  `N_SLOTS*HEALTH_W`  flat bus; slot k occupies bits `[k*HEALTH_W +: HEALTH_W]`.
- `enemy_active`  in  `N_SLOTS`  per-slot active flag.
- `spawn`  in  `N_SLOTS`  per-slot one-cycle pulse when an enemy is (re)spawned.
- `pixel`  out  4  registered palette index; 0 means transparent.

## Operation
- Per-slot state: `trail[k]` (HEALTH_W bits), `prev[k]` (HEALTH_W bits), `flash[k]` (counter). Reset clears all of them to 0 and sets `pixel` to 0.
- State update per slot k, each cycle, in priority order:
  1. If `!enemy_active[k]`: set trail, flash and prev to 0.
  2. Else if `spawn[k]`: set trail to health, flash to 0, prev to health. No flash is raised even if health dropped in the same cycle.
  3. Else:
     - Set prev to health every cycle.
     - If health < prev (damage), load flash with FLASH_FRAMES. This takes precedence over the flash decrement on a coincident `frame_tick`.
     - On `frame_tick`: if health ≥ trail, set trail to health (a heal snaps the trail up). Otherwise set trail to max(trail − TRAIL_STEP, health), computed without underflow. If no damage occurred this cycle and flash > 0, decrement flash.
- Bar hit: `is_enemy_in_pixel & enemy_active[slot_sel] & X_OFFSET ≤ x < BAR_WIDTH & y < BAR_HEIGHT`.
- Column index: `i = x − X_OFFSET`, 10 bits.
- Scaled fill widths are computed at HEALTH_W+3 bits so they cannot overflow. For h = health[slot_sel] and t = trail[slot_sel]:
  - type 0: F = h<<2, T = t<<2
  - type 1: F = h<<3, T = t<<3
  - type 2 and types 4..15: F = h, T = t
  - type 3: F = h>>2, T = t>>2
- Colour for a bar hit:
  - i < F: COL_FLASH if flash[slot_sel] bit 0 = 1, else COL_FILL.
  - F ≤ i < T: COL_TRAIL.
  - otherwise: COL_EMPTY.
- No bar hit gives 0.
- A `slot_sel` ≥ N_SLOTS (non-power-of-two N_SLOTS) is treated as inactive and gives 0.

## Timing
- `pixel` has a latency of 1 cycle from `x`, `y`, `slot_sel`, `is_enemy_in_pixel` and `enemy_type`.
- The pixel calculation uses the state values before the same-edge update, so a state change is visible on `pixel` at the earliest 2 cycles after the causing input.
- Health is sampled every cycle. A damage event shorter than one cycle cannot be represented; one cycle of lowered health is enough to raise the flash.
- `RST` asserted mid-frame: on the next edge `pixel` = 0 and all slot state = 0, regardless of any other input.
- The trail drains at most TRAIL_STEP per frame. Full drain of D units takes ceil(D / TRAIL_STEP) ticks.

## Test plan
- Reset, then slot 0 active with spawn, health 5, type 0: sweep x = 0..33 at y = 1. Required output: x = 2..21 → 6, x = 22..31 → 2, x < 2 or x ≥ 32 → 0, each value appearing one cycle later.
- Slot 1, type 2, health 20 with spawn, then health 15 held: flash = 8 and trail = 20. After 1 frame_tick, x = 17+2 → colour 4. After 5 ticks trail = 15 and that column → 2. Columns < 15 alternate 15/6 per frame.
- Damage and `frame_tick` in the same cycle with flash at 3: flash = 8 afterwards, not 2.
- Spawn and damage in the same cycle: flash stays 0 and trail = new health.
- Heal from 10 to 14 with trail 12 on a tick: trail = 14, no column drawn in colour 4.
- `enemy_active[2]` dropped mid-drain: slot 2 state clears. Reactivated with health 9 and no spawn: trail snaps to 9 on the next tick and no flash is raised.
